// File: rtl/tdc_pkg.sv
// Shared definitions for the multi-channel TDC with UART reporter.
//   state_e        : measurement FSM states
//   SYNC_BYTE_DEF  : default first byte of every result frame
//   byte_idx_w()   : width of a counter that walks 0..nbytes inclusive
package tdc_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        SEND    = 2'd2
    } state_e;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

    // The frame sequencer must also represent "all bytes issued" (== nbytes).
    function automatic int byte_idx_w(input int nbytes);
        return (nbytes < 1) ? 1 : $clog2(nbytes + 1);
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 UART byte transmitter.
//   clk, rst : clock, asynchronous active-high reset
//   data     : byte to send, taken when valid && ready
//   valid    : byte offered
//   ready    : idle, or in the final cycle of a stop bit (allows back-to-back bytes)
//   tx       : serial line, idles high, LSB first
module uart_tx_byte #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data,
    input  logic       valid,
    output logic       ready,
    output logic       tx
);

    localparam int CW = (CLKS_PER_BIT < 2) ? 1 : $clog2(CLKS_PER_BIT);

    logic          active_q, active_d;
    logic [CW-1:0] clk_cnt_q, clk_cnt_d;
    logic [3:0]    bit_idx_q, bit_idx_d;
    logic [8:0]    shift_q, shift_d;
    logic          tx_q, tx_d;
    logic          bit_end;

    assign bit_end = active_q && (clk_cnt_q == CW'(CLKS_PER_BIT - 1));
    // Ready in the last stop-bit cycle so the next start bit follows with no gap.
    assign ready   = !active_q || (bit_end && (bit_idx_q == 4'd9));
    assign tx      = tx_q;

    always_comb begin
        active_d  = active_q;
        clk_cnt_d = clk_cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        if (active_q) begin
            clk_cnt_d = clk_cnt_q + 1'b1;
            if (bit_end) begin
                clk_cnt_d = '0;
                if (bit_idx_q == 4'd9) begin
                    active_d = 1'b0;
                    tx_d     = 1'b1;
                end else begin
                    // shift_q holds the remaining data bits with the stop bit on top
                    bit_idx_d = bit_idx_q + 1'b1;
                    tx_d      = shift_q[0];
                    shift_d   = {1'b1, shift_q[8:1]};
                end
            end
        end
        if (valid && ready) begin
            active_d  = 1'b1;
            clk_cnt_d = '0;
            bit_idx_d = '0;
            shift_d   = {1'b1, data};
            tx_d      = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active_q  <= 1'b0;
            clk_cnt_q <= '0;
            bit_idx_q <= '0;
            shift_q   <= '1;
            tx_q      <= 1'b1;
        end else begin
            active_q  <= active_d;
            clk_cnt_q <= clk_cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
        end
    end

endmodule

// File: rtl/tdc_mc_uart.sv
// Multi-channel time-to-digital converter with a UART result reporter.
// Timestamps the first rising edge of each stop input relative to the start
// edge, then sends SYNC, ts[0..CHANNELS-1] (MSB byte first), status over 8N1.
//   clk, rst : clock, asynchronous active-high reset
//   start    : asynchronous start pulse (rising edge significant)
//   stop     : asynchronous stop pulses, one per channel
//   uart_tx  : serial result frame
//   busy     : measurement or frame transmission in progress
//   overflow : last measurement ended on counter timeout
module tdc_mc_uart
    import tdc_pkg::*;
#(
    parameter int         CHANNELS     = 4,
    parameter int         CNT_W        = 16,
    parameter int         CLKS_PER_BIT = 16,
    parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [CHANNELS-1:0] stop,
    output logic                uart_tx,
    output logic                busy,
    output logic                overflow
);

    localparam int NB     = CNT_W / 8;
    localparam int NBYTES = 2 + CHANNELS * NB;
    localparam int IW     = byte_idx_w(NBYTES);

    // Synchroniser + edge detect; start shares the vector so latency matches.
    logic [CHANNELS:0] sync1_q, sync2_q, sync3_q;
    logic [CHANNELS:0] sync1_d, sync2_d, sync3_d;
    logic [CHANNELS:0] edges;
    logic              start_edge;
    logic [CHANNELS-1:0] stop_edge;

    state_e                         state_q, state_d;
    logic [CNT_W-1:0]               cnt_q, cnt_d;
    logic [CHANNELS-1:0]            hit_q, hit_d;
    logic [CHANNELS-1:0][CNT_W-1:0] ts_q, ts_d;
    logic                           ovf_q, ovf_d;
    logic                           busy_q, busy_d;
    logic [IW-1:0]                  idx_q, idx_d;

    logic [CHANNELS-1:0] cap, hit_new;
    logic                all_hit, timeout;
    logic                tx_valid, tx_ready;
    logic [7:0]          tx_data, status;

    assign sync1_d    = {stop, start};
    assign sync2_d    = sync1_q;
    assign sync3_d    = sync2_q;
    assign edges      = sync2_q & ~sync3_q;
    assign start_edge = edges[0];
    assign stop_edge  = edges[CHANNELS:1];

    assign cap     = stop_edge & ~hit_q;
    assign hit_new = hit_q | cap;
    assign all_hit = &hit_new;
    assign timeout = &cnt_q;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_edge) state_d = MEASURE;
            MEASURE: if (all_hit || timeout) state_d = SEND;
            SEND:    if ((idx_q == IW'(NBYTES)) && tx_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy_d   = (state_d != IDLE);
        tx_valid = (state_q == SEND) && (idx_q != IW'(NBYTES));
    end

    // Counter, capture registers, frame sequencer
    always_comb begin
        cnt_d = cnt_q;
        hit_d = hit_q;
        ts_d  = ts_q;
        ovf_d = ovf_q;
        idx_d = idx_q;
        case (state_q)
            IDLE: begin
                if (start_edge) begin
                    cnt_d = '0;
                    hit_d = '0;
                    ovf_d = 1'b0;
                    idx_d = '0;
                end
            end
            MEASURE: begin
                cnt_d = cnt_q + 1'b1;
                hit_d = hit_new;
                for (int i = 0; i < CHANNELS; i++) begin
                    if (cap[i]) ts_d[i] = cnt_q;
                end
                if (timeout && !all_hit) begin
                    ovf_d = 1'b1;
                    for (int i = 0; i < CHANNELS; i++) begin
                        if (!hit_new[i]) ts_d[i] = '1;
                    end
                end
            end
            SEND: begin
                if (tx_valid && tx_ready) idx_d = idx_q + 1'b1;
            end
            default: ;
        endcase
    end

    // Frame byte multiplexer
    always_comb begin
        status                 = '0;
        status[CHANNELS-1:0]   = hit_q;
        tx_data                = SYNC_BYTE;
        for (int k = 0; k < CHANNELS * NB; k++) begin
            if (idx_q == IW'(k + 1)) tx_data = ts_q[k / NB][(NB - 1 - (k % NB)) * 8 +: 8];
        end
        if (idx_q == IW'(NBYTES - 1)) tx_data = status;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            sync3_q <= '0;
            cnt_q   <= '0;
            hit_q   <= '0;
            ts_q    <= '0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            idx_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            sync3_q <= sync3_d;
            cnt_q   <= cnt_d;
            hit_q   <= hit_d;
            ts_q    <= ts_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            idx_q   <= idx_d;
        end
    end

    uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
        .clk   (clk),
        .rst   (rst),
        .data  (tx_data),
        .valid (tx_valid),
        .ready (tx_ready),
        .tx    (uart_tx)
    );

    assign busy     = busy_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_tdc_mc_uart.sv
// Bench for tdc_mc_uart: default instance (A) and a small CHANNELS=1,
// CNT_W=8, CLKS_PER_BIT=4 instance (B). Frames are decoded from the line and
// compared against expectations computed from the edge schedule.
module tb_tdc_mc_uart;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       start_a, start_b;
    logic [3:0] stop_a;
    logic [0:0] stop_b;
    wire        tx_a, busy_a, ovf_a, tx_b, busy_b, ovf_b;

    tdc_mc_uart u_dut_a (
        .clk(clk), .rst(rst), .start(start_a), .stop(stop_a),
        .uart_tx(tx_a), .busy(busy_a), .overflow(ovf_a)
    );

    tdc_mc_uart #(.CHANNELS(1), .CNT_W(8), .CLKS_PER_BIT(4)) u_dut_b (
        .clk(clk), .rst(rst), .start(start_b), .stop(stop_b),
        .uart_tx(tx_b), .busy(busy_b), .overflow(ovf_b)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- line monitor ----------------
    logic sel = 1'b0;
    int   cpb = 16;
    logic mon_clr = 1'b0;
    wire  mon_tx   = sel ? tx_b   : tx_a;
    wire  mon_busy = sel ? busy_b : busy_a;
    wire  mon_ovf  = sel ? ovf_b  : ovf_a;

    logic [7:0] rx_q[$];
    int   cyc = 0, rx_act = 0, bit_n = 0, cib = 0;
    int   bad_w = 0, bad_frm = 0, rises = 0, falls = 0;
    int   rise_cyc = 0, fall_cyc = 0, st_cyc = -1;
    logic ovf_rise = 1'b0, busy_p = 1'b0, bv = 1'b1;
    logic [9:0] bits;

    always @(negedge clk) begin
        cyc++;
        if (mon_clr || rst) begin
            rx_q.delete();
            rx_act = 0; bad_w = 0; bad_frm = 0; rises = 0; falls = 0; st_cyc = -1;
            busy_p = mon_busy;
        end else begin
            if (mon_busy && !busy_p) begin rises++; rise_cyc = cyc; ovf_rise = mon_ovf; end
            if (!mon_busy && busy_p) begin falls++; fall_cyc = cyc; end
            busy_p = mon_busy;
            if (rx_act == 0 && mon_tx === 1'b0) begin
                rx_act = 1; bit_n = 0; cib = 0;
                if (st_cyc < 0) st_cyc = cyc;
            end
            if (rx_act != 0) begin
                if (cib == 0) bv = mon_tx;
                else if (mon_tx !== bv) bad_w++;
                cib++;
                if (cib == cpb) begin
                    bits[bit_n] = bv;
                    bit_n++;
                    cib = 0;
                    if (bit_n == 10) begin
                        rx_act = 0;
                        if (bits[0] !== 1'b0 || bits[9] !== 1'b1) bad_frm++;
                        rx_q.push_back(bits[8:1]);
                    end
                end
            end
        end
    end

    // ---------------- stimulus schedule ----------------
    // sp[c][j]: pin offset of stop edge j on channel c (-1 = none); xs: extra start edges
    int sp[4][2];
    int xs[2];

    task automatic clear_sched();
        for (int c = 0; c < 4; c++) begin sp[c][0] = -1; sp[c][1] = -1; end
        xs[0] = -1; xs[1] = -1;
    endtask

    task automatic mon_reset(input logic s);
        sel = s;
        cpb = s ? 4 : 16;
        mon_clr = 1'b1;
        repeat (2) @(negedge clk);
        mon_clr = 1'b0;
    endtask

    function automatic logic in_pulse(input int i, input int e);
        return (e >= 0) && (i >= e) && (i < e + 3);
    endfunction

    task automatic drive(input logic s);
        int hz;
        logic st;
        logic [3:0] sv;
        hz = 4;
        for (int c = 0; c < 4; c++)
            for (int j = 0; j < 2; j++)
                if (sp[c][j] + 4 > hz) hz = sp[c][j] + 4;
        for (int j = 0; j < 2; j++) if (xs[j] + 4 > hz) hz = xs[j] + 4;
        for (int i = 0; i <= hz; i++) begin
            @(negedge clk);
            st = in_pulse(i, 0) || in_pulse(i, xs[0]) || in_pulse(i, xs[1]);
            for (int c = 0; c < 4; c++) sv[c] = in_pulse(i, sp[c][0]) || in_pulse(i, sp[c][1]);
            if (s) begin start_b = st; stop_b = sv[0:0]; end
            else   begin start_a = st; stop_a = sv; end
        end
        @(negedge clk);
        start_a = 1'b0; stop_a = '0; start_b = 1'b0; stop_b = '0;
    endtask

    // Reference: first edge at k >= 1 with k-1 within counter range wins, ts = k-1.
    task automatic check_run(input string nm, input logic s);
        int w, ch, nb, maxc, m, fl, limit;
        int ts[4];
        logic [3:0] hit;
        logic all;
        logic [7:0] ex[$];
        w = s ? 8 : 16; ch = s ? 1 : 4; nb = w / 8; maxc = (2 ** w) - 1;
        hit = '0; m = 0;
        for (int c = 0; c < ch; c++) begin
            ts[c] = maxc;
            for (int j = 0; j < 2; j++) begin
                if (!hit[c] && sp[c][j] >= 1 && sp[c][j] - 1 <= maxc) begin
                    hit[c] = 1'b1; ts[c] = sp[c][j] - 1;
                end
            end
        end
        all = 1'b1;
        for (int c = 0; c < ch; c++) begin
            if (!hit[c]) all = 1'b0;
            else if (ts[c] + 1 > m) m = ts[c] + 1;
        end
        if (!all) m = maxc + 1;
        ex.push_back(8'hA5);
        for (int c = 0; c < ch; c++)
            for (int b = nb - 1; b >= 0; b--) ex.push_back(8'((ts[c] >> (8 * b)) & 255));
        ex.push_back(8'(hit & ((1 << ch) - 1)));
        fl = (2 + ch * nb) * 10 * cpb;
        limit = m + fl + 400;
        for (int t = 0; t < limit && falls < 1; t++) @(negedge clk);
        chk({nm, ".done"}, falls, 1);
        repeat (30) @(negedge clk);
        chk({nm, ".frames"}, rises, 1);
        chk({nm, ".nbytes"}, rx_q.size(), ex.size());
        for (int i = 0; i < ex.size(); i++)
            if (i < rx_q.size()) chk($sformatf("%s.byte%0d", nm, i), rx_q[i], ex[i]);
        chk({nm, ".ovf"}, mon_ovf, !all);
        chk({nm, ".ovf_clr"}, ovf_rise, 0);
        chk({nm, ".busy_len"}, fall_cyc - rise_cyc, m + 1 + fl);
        chk({nm, ".frame_len"}, fall_cyc - st_cyc, fl);
        chk({nm, ".bit_width"}, bad_w, 0);
        chk({nm, ".framing"}, bad_frm, 0);
    endtask

    task automatic run(input string nm, input logic s);
        mon_reset(s);
        drive(s);
        check_run(nm, s);
    endtask

    initial begin
        rst = 1'b1;
        start_a = 1'b0; stop_a = '0; start_b = 1'b0; stop_b = '0;
        repeat (3) @(negedge clk);
        chk("rst.tx_a", tx_a, 1);
        chk("rst.busy_a", busy_a, 0);
        chk("rst.ovf_a", ovf_a, 0);
        chk("rst.tx_b", tx_b, 1);
        chk("rst.busy_b", busy_b, 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // normal capture
        clear_sched();
        sp[0][0] = 10; sp[1][0] = 300; sp[2][0] = 300; sp[3][0] = 5000;
        run("normal", 1'b0);

        // ignored edges: repeat on hit channel, stop coincident with start
        clear_sched();
        sp[0][0] = 20; sp[0][1] = 50; sp[1][0] = 0; sp[1][1] = 60;
        sp[2][0] = 100; sp[3][0] = 150;
        run("ignored", 1'b0);

        // start edges during MEASURE and during SEND
        clear_sched();
        sp[0][0] = 20; sp[1][0] = 30; sp[2][0] = 40; sp[3][0] = 50;
        xs[0] = 25; xs[1] = 860;
        run("startbusy", 1'b0);

        // timeout
        clear_sched();
        sp[0][0] = 1;
        run("timeout", 1'b0);

        // randomized; the first also confirms overflow clears on a new start
        for (int r = 0; r < 3; r++) begin
            clear_sched();
            for (int c = 0; c < 4; c++) begin
                sp[c][0] = $urandom_range(0, 150);
                sp[c][1] = sp[c][0] + $urandom_range(6, 80);
            end
            run($sformatf("rnd%0d", r), 1'b0);
        end

        // stop edges in IDLE only
        mon_reset(1'b0);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            stop_a = (i % 10 < 3) ? 4'hF : 4'h0;
        end
        stop_a = '0;
        repeat (20) @(negedge clk);
        chk("idle.frames", rises, 0);
        chk("idle.bytes", rx_q.size(), 0);

        // reset during byte 4
        clear_sched();
        sp[0][0] = 10; sp[1][0] = 12; sp[2][0] = 14; sp[3][0] = 16;
        mon_reset(1'b0);
        drive(1'b0);
        for (int t = 0; t < 3000 && rx_q.size() < 3; t++) @(negedge clk);
        chk("rstmid.reach", rx_q.size() >= 3, 1);
        for (int t = 0; t < 400 && tx_a !== 1'b0; t++) @(negedge clk);
        chk("rstmid.pre_tx", tx_a, 0);
        chk("rstmid.pre_busy", busy_a, 1);
        #2 rst = 1'b1;
        #1;
        chk("rstmid.tx", tx_a, 1);
        chk("rstmid.busy", busy_a, 0);
        chk("rstmid.ovf", ovf_a, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        clear_sched();
        sp[0][0] = 33; sp[1][0] = 7; sp[2][0] = 120; sp[3][0] = 64;
        run("after_rst", 1'b0);

        // small instance: fixed, then random (may hit its 256-cycle timeout)
        clear_sched();
        sp[0][0] = 7;
        run("sweep", 1'b1);
        for (int r = 0; r < 3; r++) begin
            clear_sched();
            sp[0][0] = $urandom_range(0, 300);
            sp[0][1] = sp[0][0] + $urandom_range(6, 40);
            run($sformatf("sweep_rnd%0d", r), 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
